// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, prioritised redirects, timed flush,
// and a halt on misaligned jump/branch targets until a trap redirect.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        trap_req,
   input  logic [31:0] trap_vector,
   input  logic        fetch_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_addr,
   output logic        flush,
   output logic        misalign_exc,
   output logic [31:0] misalign_addr,
   output logic [15:0] redirect_count
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_FLUSH,
      S_HALT
   } state_t;

   localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

   state_t      r_state;
   logic [3:0]  r_fcnt;
   logic        r_valid;
   logic        r_flush;
   logic        r_exc;
   logic [31:0] r_pc;
   logic [31:0] r_maddr;
   logic [15:0] r_cnt;

   logic        w_halted;
   logic        w_take_jump;
   logic        w_take_br;
   logic        w_redir;
   logic [31:0] w_target;
   logic        w_misalign;

   // While halted only a trap can restart fetch
   assign w_halted    = (r_state == S_HALT);
   assign w_take_jump = !trap_req && jump_taken && !w_halted;
   assign w_take_br   = !trap_req && !jump_taken && branch_taken
                        && !w_halted;
   assign w_redir     = trap_req || w_take_jump || w_take_br;
   assign w_target    = trap_req   ? trap_vector :
                        jump_taken ? jump_target : branch_target;
   assign w_misalign  = !trap_req && (w_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_BOOT;
         r_fcnt  <= 4'd0;
         r_valid <= 1'b0;
         r_flush <= 1'b0;
         r_exc   <= 1'b0;
         r_pc    <= RESET_PC;
         r_maddr <= 32'd0;
         r_cnt   <= 16'd0;
      end else begin
         r_exc <= 1'b0;
         if (w_redir && w_misalign) begin
            r_state <= S_HALT;
            r_fcnt  <= 4'd0;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_exc   <= 1'b1;
            r_maddr <= w_target;
         end else if (w_redir) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FC;
            r_valid <= 1'b0;
            r_flush <= 1'b1;
            r_pc    <= w_target;
            if (r_cnt != 16'hFFFF)
               r_cnt <= r_cnt + 16'd1;
         end else begin
            unique case (r_state)
               S_BOOT: begin
                  r_state <= S_FETCH;
                  r_valid <= 1'b1;
               end
               S_FETCH: begin
                  if (fetch_ready && !stall)
                     r_pc <= r_pc + 32'd4;
               end
               S_FLUSH: begin
                  // last flush cycle hands over to fetch at the target
                  if (r_fcnt <= 4'd1) begin
                     r_state <= S_FETCH;
                     r_fcnt  <= 4'd0;
                     r_valid <= 1'b1;
                     r_flush <= 1'b0;
                  end else begin
                     r_fcnt <= r_fcnt - 4'd1;
                  end
               end
               S_HALT: begin
                  r_valid <= 1'b0;
               end
               default: begin
                  r_state <= S_BOOT;
               end
            endcase
         end
      end
   end

   assign fetch_valid    = r_valid;
   assign fetch_addr     = r_pc;
   assign flush          = r_flush;
   assign misalign_exc   = r_exc;
   assign misalign_addr  = r_maddr;
   assign redirect_count = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios with literal checks,
// then random traffic against a cycle model compared every cycle.
module tb_pc_redirect_ctrl;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        jump_taken = 1'b0;
   logic [31:0] jump_target = 32'd0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        trap_req = 1'b0;
   logic [31:0] trap_vector = 32'd0;
   logic        fetch_ready = 1'b1;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        flush;
   logic        misalign_exc;
   logic [31:0] misalign_addr;
   logic [15:0] redirect_count;

   pc_redirect_ctrl #(
      .RESET_PC    (32'h0000_0000),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .jump_taken    (jump_taken),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .trap_req      (trap_req),
      .trap_vector   (trap_vector),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .fetch_addr    (fetch_addr),
      .flush         (flush),
      .misalign_exc  (misalign_exc),
      .misalign_addr (misalign_addr),
      .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // model: fetch is live when not booting, not flushing, not halted
   logic [31:0] m_pc;
   logic [31:0] m_maddr;
   int          m_flush_left;
   bit          m_halted;
   bit          m_boot;
   bit          m_exc;
   int          m_cnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic m_reset();
      m_pc = 32'd0;
      m_maddr = 32'd0;
      m_flush_left = 0;
      m_halted = 1'b0;
      m_boot = 1'b1;
      m_exc = 1'b0;
      m_cnt = 0;
   endtask

   task automatic m_step();
      bit          sel;
      bit          trusted;
      logic [31:0] t;
      if (rst) begin
         m_reset();
         return;
      end
      sel = 1'b1;
      trusted = 1'b0;
      t = 32'd0;
      if (trap_req) begin
         t = trap_vector;
         trusted = 1'b1;
      end else if (!m_halted && jump_taken)
         t = jump_target;
      else if (!m_halted && branch_taken)
         t = branch_target;
      else
         sel = 1'b0;
      m_exc = 1'b0;
      if (sel) begin
         m_boot = 1'b0;
         if (trusted || t[1:0] == 2'b00) begin
            m_pc = t;
            m_flush_left = FC;
            m_halted = 1'b0;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            m_exc = 1'b1;
            m_maddr = t;
            m_halted = 1'b1;
            m_flush_left = 0;
         end
      end else if (m_boot)
         m_boot = 1'b0;
      else if (m_flush_left > 0)
         m_flush_left--;
      else if (!m_halted && fetch_ready && !stall)
         m_pc = m_pc + 32'd4;
   endtask

   task automatic m_compare();
      bit exp_valid;
      exp_valid = !m_boot && m_flush_left == 0 && !m_halted;
      chk("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
      chk("fetch_addr", fetch_addr, m_pc);
      chk("flush", 32'(flush), 32'(m_flush_left > 0));
      chk("misalign_exc", 32'(misalign_exc), 32'(m_exc));
      chk("misalign_addr", misalign_addr, m_maddr);
      chk("redirect_count", 32'(redirect_count), 32'(m_cnt));
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         m_step();
         #1;
         if (chk_en) m_compare();
      end
   end

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic idle();
      jump_taken = 1'b0;
      branch_taken = 1'b0;
      trap_req = 1'b0;
   endtask

   task automatic redirect_jump(input logic [31:0] t);
      jump_taken = 1'b1;
      jump_target = t;
      nclk();
      idle();
   endtask

   initial begin
      nclk();
      nclk();
      chk_en = 1'b1;
      chk("rst valid", 32'(fetch_valid), 32'd0);
      chk("rst addr", fetch_addr, 32'h0);
      chk("rst count", 32'(redirect_count), 32'd0);
      rst = 1'b0;
      nclk();
      chk("boot->fetch addr0", fetch_addr, 32'h0);
      chk("boot->fetch valid", 32'(fetch_valid), 32'd1);
      nclk();
      chk("seq addr4", fetch_addr, 32'h4);
      nclk();
      chk("seq addr8", fetch_addr, 32'h8);

      redirect_jump(32'h24);
      chk("jump flush1", 32'(flush), 32'd1);
      chk("jump valid0", 32'(fetch_valid), 32'd0);
      chk("jump count", 32'(redirect_count), 32'd1);
      nclk();
      chk("jump flush2", 32'(flush), 32'd1);
      nclk();
      chk("jump flush end", 32'(flush), 32'd0);
      chk("jump resume valid", 32'(fetch_valid), 32'd1);
      chk("jump resume addr", fetch_addr, 32'h24);

      trap_req = 1'b1;
      trap_vector = 32'h100;
      jump_taken = 1'b1;
      jump_target = 32'h40;
      branch_taken = 1'b1;
      branch_target = 32'h80;
      nclk();
      idle();
      nclk();
      nclk();
      chk("prio addr", fetch_addr, 32'h100);
      chk("prio count", 32'(redirect_count), 32'd2);

      redirect_jump(32'h22);
      chk("misalign pulse", 32'(misalign_exc), 32'd1);
      chk("misalign addr", misalign_addr, 32'h22);
      chk("misalign valid", 32'(fetch_valid), 32'd0);
      branch_taken = 1'b1;
      branch_target = 32'h80;
      nclk();
      idle();
      chk("misalign one-shot", 32'(misalign_exc), 32'd0);
      chk("halt ignores branch", 32'(flush), 32'd0);
      chk("halt count", 32'(redirect_count), 32'd2);
      trap_req = 1'b1;
      trap_vector = 32'h200;
      nclk();
      idle();
      nclk();
      nclk();
      chk("trap resume addr", fetch_addr, 32'h200);
      chk("trap resume valid", 32'(fetch_valid), 32'd1);

      redirect_jump(32'h10);
      nclk();
      nclk();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nclk();
         chk("stall hold", fetch_addr, 32'h10);
         chk("stall valid", 32'(fetch_valid), 32'd1);
      end
      stall = 1'b0;
      fetch_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         nclk();
         chk("notready hold", fetch_addr, 32'h10);
      end
      fetch_ready = 1'b1;
      stall = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h50;
      nclk();
      idle();
      stall = 1'b0;
      nclk();
      nclk();
      chk("stall branch addr", fetch_addr, 32'h50);

      redirect_jump(32'hFFFF_FFFC);
      nclk();
      nclk();
      chk("wrap pre", fetch_addr, 32'hFFFF_FFFC);
      nclk();
      chk("wrap post", fetch_addr, 32'h0);

      redirect_jump(32'h40);
      #2 rst = 1'b1;
      #1;
      m_reset();
      chk("async rst flush", 32'(flush), 32'd0);
      chk("async rst addr", fetch_addr, 32'h0);
      chk("async rst count", 32'(redirect_count), 32'd0);
      nclk();
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         int r;
         nclk();
         r = int'($urandom_range(0, 99));
         rst = (r == 0);
         stall = ($urandom_range(0, 3) == 0);
         fetch_ready = ($urandom_range(0, 3) != 0);
         trap_req = ($urandom_range(0, 24) == 0);
         jump_taken = ($urandom_range(0, 11) == 0);
         branch_taken = ($urandom_range(0, 9) == 0);
         trap_vector = $urandom & 32'hFFFF_FFFC;
         jump_target = $urandom;
         branch_target = $urandom;
         if ($urandom_range(0, 3) != 0)
            jump_target[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0)
            branch_target[1:0] = 2'b00;
         if ($urandom_range(0, 9) == 0)
            trap_vector[1:0] = 2'b10;
      end
      nclk();
      rst = 1'b0;
      idle();
      nclk();
      nclk();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
